// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns a single-cycle LW/SW request from execute into a
// registered request/ready handshake toward data memory, stalling the
// pipeline until the access completes and returning load data with a
// one-cycle valid pulse.
// Optional build macro: MEM_TIMEOUT_EN (abort an access after TIMEOUT_CYC
// cycles without mem_ready).
//
// Handshake: mem_en is a held request. The memory samples it on every edge
// where mem_en=1 and completes the access on the edge where mem_ready=1.
// mem_en, mem_wr, mem_addr and mem_wdata stay stable from the request edge
// until that completion edge. mem_ready outside ACCESS is ignored.
module mem_access_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;
  logic              w_stall;
  logic              w_start;
  logic              w_illegal;
  logic              w_timeout;
  logic              w_unused_addr0;

  // Word alignment discards the byte-select bit.
  assign w_unused_addr0 = addr[0];

  assign w_start   = op_valid & (mem_read ^ mem_write);
  assign w_illegal = op_valid & mem_read & mem_write;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  // The last waited cycle is the one where the counter would reach TIMEOUT_CYC.
  assign w_timeout = (r_state == ACCESS) && !mem_ready &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Wait counter: cleared on entry to ACCESS, counts ACCESS cycles without ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && w_start) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS && !mem_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and stall decode.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_start;
        if (w_start) w_next = ACCESS;
      end
      ACCESS: begin
        w_stall = 1'b1;
        if (mem_ready || w_timeout) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (!rst_n) w_stall = 1'b0;
  end

  // Request, load-data and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_mem_en    <= 1'b1;
            r_mem_wr    <= mem_write;
            r_mem_addr  <= {addr[ADDR_W-1:1], 1'b0};
            r_mem_wdata <= write_data;
          end
          if (w_illegal) r_err <= 1'b1;
        end
        ACCESS: begin
          if (mem_ready) begin
            r_mem_en <= 1'b0;
            if (!r_mem_wr) begin
              r_rd_data  <= mem_rdata;
              r_rd_valid <= 1'b1;
            end
          end else if (w_timeout) begin
            r_mem_en <= 1'b0;
            r_err    <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign err       = r_err;
  assign stall     = w_stall;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: table of single transactions applied
// back-to-back, plus hand-written reset-abort and timeout sequences.
module tb_mem_access_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          stall;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int rdv_pulses = 0;
  int exp_pulses = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .mem_read(mem_read),
    .mem_write(mem_write), .addr(addr), .write_data(write_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Count rd_valid pulses, sampled away from the active edge.
  always @(negedge clk) if (rst_n && rd_valid) rdv_pulses++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            waits;
    logic [DW-1:0] rdat;
    logic [AW-1:0] exp_addr;
    logic          exp_stall0;
    logic          exp_err;
  } vec_t;

  // One transaction starting in IDLE; returns in IDLE one cycle after DONE.
  task automatic run_op(input vec_t v);
    op_valid = 1'b1; mem_read = v.rd; mem_write = v.wr;
    addr = v.a; write_data = v.wd; mem_ready = 1'b0;
    #1;
    chk("stall_req", stall, v.exp_stall0);
    if (!(v.rd ^ v.wr)) begin
      tick();
      op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      chk("noop_mem_en", mem_en, 1'b0);
      chk("noop_err", err, v.exp_err);
      chk("noop_state", dbg_state, S_IDLE);
      #1;
      chk("noop_stall", stall, 1'b0);
      tick();
      chk("noop_err_clr", err, 1'b0);
      return;
    end
    if (v.rd) exp_q.push_back(v.rdat);
    tick();
    op_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    for (int w = 0; w <= v.waits; w++) begin
      chk("acc_mem_en", mem_en, 1'b1);
      chk("acc_mem_wr", mem_wr, v.wr);
      chk("acc_mem_addr", mem_addr, v.exp_addr);
      if (v.wr) chk("acc_mem_wdata", mem_wdata, v.wd);
      chk("acc_stall", stall, 1'b1);
      chk("acc_rd_valid", rd_valid, 1'b0);
      if (w == v.waits) begin
        mem_ready = 1'b1; mem_rdata = v.rdat;
      end else begin
        mem_ready = 1'b0; mem_rdata = 16'hDEAD;
      end
      tick();
      mem_ready = 1'b0;
    end
    chk("done_state", dbg_state, S_DONE);
    chk("done_stall", stall, 1'b0);
    chk("done_mem_en", mem_en, 1'b0);
    chk("done_rd_valid", rd_valid, v.rd);
    chk("done_err", err, 1'b0);
    if (v.rd) begin
      exp_pulses++;
      if (exp_q.size() == 0) chk("scb_empty", 1, 0);
      else begin
        last_rd = exp_q.pop_front();
        chk("done_rd_data", rd_data, last_rd);
      end
    end else begin
      chk("wr_rd_data_kept", rd_data, last_rd);
    end
    tick();
    chk("post_state", dbg_state, S_IDLE);
    chk("post_rd_valid", rd_valid, 1'b0);
  endtask

  vec_t vecs[6];

  initial begin
    // rd, wr, addr, wdata, waits, rdata, exp_addr, exp_stall0, exp_err
    vecs[0] = '{1'b1, 1'b0, 16'h1235, 16'h0000, 0, 16'hBEEF, 16'h1234, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'h0040, 16'hA5A5, 3, 16'h0000, 16'h0040, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'h0100, 16'h1111, 0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 16'h0200, 16'h2222, 0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 2, 16'h1357, 16'hFFFE, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'h0003, 16'h00FF, 0, 16'h0000, 16'h0002, 1'b1, 1'b0};
    last_rd = '0;

    // Reset state, with a request presented while reset is held.
    op_valid = 1'b1; mem_read = 1'b1;
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_state", dbg_state, S_IDLE);
    op_valid = 1'b0; mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Table vectors, presented back-to-back (load at [4] then store at [5]).
    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Reset in the middle of an access, with ready arriving during reset.
    op_valid = 1'b1; mem_read = 1'b1; addr = 16'h0800;
    tick();
    op_valid = 1'b0; mem_read = 1'b0;
    chk("mid_mem_en", mem_en, 1'b1);
    chk("mid_state", dbg_state, S_ACCESS);
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1; mem_rdata = 16'h9999;
    #1;
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_stall", stall, 1'b0);
    chk("abort_rd_valid", rd_valid, 1'b0);
    chk("abort_state", dbg_state, S_IDLE);
    tick();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    last_rd = '0;
    tick();
    chk("abort_rd_data", rd_data, 16'h0000);
    chk("abort_rd_valid2", rd_valid, 1'b0);
    begin
      vec_t v;
      v = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1, 16'h4321, 16'h0002, 1'b1, 1'b0};
      run_op(v);
    end

`ifdef MEM_TIMEOUT_EN
    // Access that never gets ready: aborted after 4 ACCESS cycles.
    op_valid = 1'b1; mem_read = 1'b1; addr = 16'h0A0A; mem_ready = 1'b0;
    tick();
    op_valid = 1'b0; mem_read = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to_mem_en", mem_en, 1'b1);
      chk("to_stall", stall, 1'b1);
      chk("to_err_low", err, 1'b0);
      tick();
    end
    chk("to_mem_en_drop", mem_en, 1'b0);
    chk("to_err", err, 1'b1);
    chk("to_stall_drop", stall, 1'b0);
    chk("to_rd_valid", rd_valid, 1'b0);
    chk("to_rd_data", rd_data, last_rd);
    chk("to_state", dbg_state, S_DONE);
    tick();
    chk("to_err_clr", err, 1'b0);
    chk("to_idle", dbg_state, S_IDLE);
`endif

    tick();
    chk("rd_valid_pulses", rdv_pulses, exp_pulses);
    chk("scb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
